outport_out_interface_buf: RTL and testbench
============================================

Name: outport_out_interface_buf

Overview:
- Transmit-side interface buffer for a router output port.
- Accepts whole flits from the switch/crossbar and queues them in a circular FIFO.
- Launches flits one per cycle onto the inter-router link toward a downstream input-port buffer, honouring that buffer's pre_full/full backpressure.
- Tracks packet framing (head/tail) and flags framing violations.

Parameters:
flit_size, 2, phits per flit
phit_size, 16, bits per phit
buf_size, 10, FIFO depth in flits (need not be a power of two)
floorplusone_log2_buf_size, 4, width of pointers and count (floor(log2(buf_size))+1)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
indata  in  flit_size*phit_size  flit from switch
in_new  in  1  indata/in_head/in_tail valid this cycle (write request)
in_head  in  1  flit is a packet header
in_tail  in  1  flit is a packet tail
ds_pre_full  in  1  downstream buffer will be full; sampling it high blocks launch
ds_full  in  1  downstream buffer full; sampling it high blocks launch
outdata  out  flit_size*phit_size  flit on link
out_new  out  1  one-cycle strobe: outdata is a new flit
out_valid  out  1  qualifies out_new (the downstream receiver uses in_new&valid)
out_head  out  1  header flag of launched flit
out_tail  out  1  tail flag of launched flit
pre_full  out  1  combinational: count>=buf_size-1, or count==buf_size-2 with in_new=1
full  out  1  registered: count==buf_size
empty  out  1  registered: count==0
count  out  floorplusone_log2_buf_size  registered occupancy
overflow  out  1  sticky: write attempted while full with no same-cycle pop
frame_err  out  1  sticky: packet framing violation detected

Behaviour:
- Reset (reset=1 at an edge):
  - Outputs: outdata=0, out_new=0, out_valid=0, out_head=0, out_tail=0, full=0, empty=1, count=0, overflow=0, frame_err=0.
  - Internal: head and tail pointers=0, all type fields=00, FSM=IDLE.
  - Reset mid-packet discards all queued flits. The in-progress packet is not terminated on the link.
- Storage:
  - Each entry holds data plus a 2-bit type: bit0=head, bit1=tail.
  - Pointers increment and wrap buf_size-1 -> 0.
- Write: on an edge with in_new=1, the flit is stored at the tail pointer and the tail pointer advances, if any of the following holds:
  - count<buf_size;
  - count==buf_size and a pop occurs in the same cycle.
  - Otherwise the flit is dropped and overflow is set to 1.
- Launch condition, evaluated at each edge: pop when empty=0 AND ds_pre_full=0 AND ds_full=0.
  - On pop: outdata/out_head/out_tail are loaded from the head entry, out_new=1, out_valid=1, and the head pointer advances.
  - On non-pop cycles: out_new=0 and out_valid=0; outdata, out_head and out_tail hold their last values.
- No bypass. A flit written at edge N is first launchable at edge N+1.
  - Minimum latency from in_new to out_new: 1 cycle.
  - Sustained throughput: 1 flit/cycle.
- Simultaneous write and pop: count is unchanged; full and empty are unchanged.
- count, full and empty always reflect the post-edge occupancy.
- Framing FSM, updated only on pops:
  - IDLE:
    - Pop of a head-only entry (head=1, tail=0): go to PKT.
    - Pop of a head+tail entry: single-flit packet, stay in IDLE.
    - Pop of an entry with head=0: set frame_err, stay in IDLE. The flit is still launched.
  - PKT:
    - Pop with tail=1 and head=0: go to IDLE.
    - Pop with head=1: set frame_err. Next state is PKT if tail=0, IDLE if tail=1.
    - Pop with head=0, tail=0: stay in PKT.
- frame_err and overflow clear only on reset.
- Backpressure arriving mid-packet stalls launch for as many cycles as it stays asserted. Flit order and flags are preserved.

Test Plan:
- Reset then idle: after reset, empty=1, full=0, count=0, out_new=0, outdata=0 for 5 cycles with in_new=0.
- Single packet: write head 0xAAAA0001, body 0x00000002, tail 0x00000003 on consecutive cycles with ds_pre_full=0. Require out_new on cycles 1-3 after the first write, data and flags (01,00,10) in order, and the FSM back in IDLE with frame_err=0.
- Fill to full: hold ds_pre_full=1 and write 10 flits. Require count=10, full=1, pre_full=1 from count 8 with in_new=1. An 11th write sets overflow=1 and count stays 10.
- Simultaneous push/pop at full: with count=10 set ds_pre_full=0 and in_new=1. Require count to stay 10, no overflow, and pointer wrap (tail 9->0) with correct data order.
- Backpressure mid-packet: toggle ds_full high for 3 cycles after the head launches. Require out_new=0 for exactly those 3 cycles, then body and tail launch back to back.
- Framing error: write a body flit (type 00) first. Require it to launch with frame_err=1. Then assert reset and require frame_err=0, empty=1.

Source files
------------

// File: rtl/outport_out_interface_buf.sv
// Transmit-side buffer for a router output port: a circular flit FIFO that
// launches one flit per cycle onto the link under downstream backpressure.
module outport_out_interface_buf #(
  parameter int flit_size                  = 2,
  parameter int phit_size                  = 16,
  parameter int buf_size                   = 10,
  parameter int floorplusone_log2_buf_size = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [flit_size*phit_size-1:0]        indata,
  input  logic                                  in_new,
  input  logic                                  in_head,
  input  logic                                  in_tail,
  input  logic                                  ds_pre_full,
  input  logic                                  ds_full,
  output logic [flit_size*phit_size-1:0]        outdata,
  output logic                                  out_new,
  output logic                                  out_valid,
  output logic                                  out_head,
  output logic                                  out_tail,
  output logic                                  pre_full,
  output logic                                  full,
  output logic                                  empty,
  output logic [floorplusone_log2_buf_size-1:0] count,
  output logic                                  overflow,
  output logic                                  frame_err
);
  localparam int W  = flit_size * phit_size;
  localparam int PW = floorplusone_log2_buf_size;
  localparam logic [PW-1:0] C_BUF  = PW'(buf_size);
  localparam logic [PW-1:0] C_LAST = PW'(buf_size - 1);
  localparam logic [PW-1:0] C_M2   = PW'(buf_size - 2);

  typedef enum logic {S_IDLE, S_PKT} state_t;

  logic [W-1:0]  r_data [buf_size];
  logic [1:0]    r_type [buf_size];   // bit0 = head, bit1 = tail
  logic [PW-1:0] r_hd, r_tl, r_cnt;
  logic          r_full, r_empty, r_ovf, r_ferr;
  logic [W-1:0]  r_odata;
  logic          r_onew, r_ohead, r_otail;
  state_t        r_st, w_st_nxt;

  logic          w_pop, w_wr, w_ferr_set;
  logic [1:0]    w_hd_type;
  logic [PW-1:0] w_cnt_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == C_LAST) ? '0 : p + 1'b1;
  endfunction

  // Launch only from registered state; a flit written this edge waits a cycle.
  assign w_pop     = !r_empty && !ds_pre_full && !ds_full;
  assign w_wr      = in_new && ((r_cnt != C_BUF) || w_pop);
  assign w_hd_type = r_type[r_hd];

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_wr, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk)
    if (w_wr) r_data[r_tl] <= indata;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < buf_size; i++) r_type[i] <= 2'b00;
      r_hd    <= '0;
      r_tl    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
      r_ferr  <= 1'b0;
      r_odata <= '0;
      r_onew  <= 1'b0;
      r_ohead <= 1'b0;
      r_otail <= 1'b0;
    end else begin
      if (w_wr) begin
        r_type[r_tl] <= {in_tail, in_head};
        r_tl         <= ptr_inc(r_tl);
      end
      if (in_new && !w_wr) r_ovf <= 1'b1;
      if (w_ferr_set)      r_ferr <= 1'b1;
      r_onew <= w_pop;
      if (w_pop) begin
        r_odata <= r_data[r_hd];
        r_ohead <= w_hd_type[0];
        r_otail <= w_hd_type[1];
        r_hd    <= ptr_inc(r_hd);
      end
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == C_BUF);
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  // Framing FSM: advances only on launched flits.
  always_ff @(posedge clk) begin
    if (reset) r_st <= S_IDLE;
    else       r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = r_st;
    if (w_pop) begin
      case (r_st)
        S_IDLE:  if (w_hd_type[0] && !w_hd_type[1]) w_st_nxt = S_PKT;
        S_PKT:   if (w_hd_type[1]) w_st_nxt = S_IDLE;
        default: w_st_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ferr_set = 1'b0;
    if (w_pop)
      w_ferr_set = (r_st == S_IDLE) ? !w_hd_type[0] : w_hd_type[0];
  end

  assign pre_full  = (r_cnt >= C_LAST) || ((r_cnt == C_M2) && in_new);
  assign outdata   = r_odata;
  assign out_new   = r_onew;
  assign out_valid = r_onew;
  assign out_head  = r_ohead;
  assign out_tail  = r_otail;
  assign full      = r_full;
  assign empty     = r_empty;
  assign count     = r_cnt;
  assign overflow  = r_ovf;
  assign frame_err = r_ferr;
endmodule

// File: tb/tb_outport_out_interface_buf.sv
// Directed vector bench for outport_out_interface_buf: per-cycle expected link
// outputs, occupancy and sticky flags.
module tb_outport_out_interface_buf;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] indata;
  logic        in_new, in_head, in_tail, ds_pre_full, ds_full;
  logic [31:0] outdata;
  logic        out_new, out_valid, out_head, out_tail;
  logic        pre_full, full, empty, overflow, frame_err;
  logic [3:0]  count;

  always #5 clk = ~clk;

  outport_out_interface_buf dut (
    .clk(clk), .reset(reset), .indata(indata), .in_new(in_new),
    .in_head(in_head), .in_tail(in_tail), .ds_pre_full(ds_pre_full),
    .ds_full(ds_full), .outdata(outdata), .out_new(out_new),
    .out_valid(out_valid), .out_head(out_head), .out_tail(out_tail),
    .pre_full(pre_full), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .frame_err(frame_err)
  );

  typedef struct {
    logic        nw;  logic [31:0] d;  logic h, t, dpf, dfu;
    logic        onew; logic [31:0] od; logic oh, ot;
    int          cnt; logic ovf, ferr, pf;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;
  int   vidx   = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %0h want %0h", name, vidx, act, exp);
    end
  endtask

  task automatic add(input logic nw, input logic [31:0] d, input logic h, input logic t,
                     input logic dpf, input logic dfu, input logic onew, input logic [31:0] od,
                     input logic oh, input logic ot, input int cnt, input logic ovf,
                     input logic ferr, input logic pf);
    vec_t v;
    v.nw = nw; v.d = d; v.h = h; v.t = t; v.dpf = dpf; v.dfu = dfu;
    v.onew = onew; v.od = od; v.oh = oh; v.ot = ot;
    v.cnt = cnt; v.ovf = ovf; v.ferr = ferr; v.pf = pf;
    vq.push_back(v);
  endtask

  task automatic drive(input logic nw, input logic [31:0] d, input logic h,
                       input logic t, input logic dpf, input logic dfu);
    in_new = nw; indata = d; in_head = h; in_tail = t;
    ds_pre_full = dpf; ds_full = dfu;
  endtask

  task automatic chk_post(input logic onew, input logic [31:0] od, input logic oh,
                          input logic ot, input int cnt, input logic ovf, input logic ferr);
    chk("out_new",   32'(out_new),   32'(onew));
    chk("out_valid", 32'(out_valid), 32'(onew));
    chk("outdata",   outdata,        od);
    chk("out_head",  32'(out_head),  32'(oh));
    chk("out_tail",  32'(out_tail),  32'(ot));
    chk("count",     32'(count),     32'(cnt));
    chk("full",      32'(full),      32'(cnt == 10));
    chk("empty",     32'(empty),     32'(cnt == 0));
    chk("overflow",  32'(overflow),  32'(ovf));
    chk("frame_err", 32'(frame_err), 32'(ferr));
  endtask

  initial begin
    // idle after reset
    for (int i = 0; i < 5; i++) add(0,0,0,0,0,0, 0,0,0,0, 0,0,0,0);
    // single packet head/body/tail
    add(1,32'hAAAA0001,1,0,0,0, 0,0,0,0,            1,0,0,0);
    add(1,32'h00000002,0,0,0,0, 1,32'hAAAA0001,1,0, 1,0,0,0);
    add(1,32'h00000003,0,1,0,0, 1,32'h00000002,0,0, 1,0,0,0);
    add(0,0,0,0,0,0,            1,32'h00000003,0,1, 0,0,0,0);
    add(0,0,0,0,0,0,            0,32'h00000003,0,1, 0,0,0,0);
    // fill to full under ds_pre_full
    for (int i = 0; i < 10; i++)
      add(1,32'h10000000+i,1,1,1,0, 0,32'h3,0,1, i+1,0,0,(i >= 8));
    // push and pop at full: count stays 10, tail wraps
    for (int j = 0; j < 3; j++)
      add(1,32'h20000000+j,1,1,0,0, 1,32'h10000000+j,1,1, 10,0,0,1);
    // write at full with no pop is dropped
    add(1,32'h0000DEAD,1,1,1,0, 0,32'h10000002,1,1, 10,1,0,1);
    // drain: remaining fill flits then the push/pop flits, no DEAD
    for (int k = 0; k < 10; k++)
      add(0,0,0,0,0,0, 1,(k < 7) ? 32'h10000003+k : 32'h20000000+(k-7),1,1,
          9-k,1,0,(k < 2));
    add(0,0,0,0,0,0, 0,32'h20000002,1,1, 0,1,0,0);
    // backpressure for 3 cycles after the head launches
    add(1,32'h30000001,1,0,0,0, 0,32'h20000002,1,1, 1,1,0,0);
    add(1,32'h30000002,0,0,0,0, 1,32'h30000001,1,0, 1,1,0,0);
    add(1,32'h30000003,0,1,0,1, 0,32'h30000001,1,0, 2,1,0,0);
    add(0,0,0,0,0,1,            0,32'h30000001,1,0, 2,1,0,0);
    add(0,0,0,0,0,1,            0,32'h30000001,1,0, 2,1,0,0);
    add(0,0,0,0,0,0,            1,32'h30000002,0,0, 1,1,0,0);
    add(0,0,0,0,0,0,            1,32'h30000003,0,1, 0,1,0,0);
    add(0,0,0,0,0,0,            0,32'h30000003,0,1, 0,1,0,0);
    // body flit with no packet open: launched, frame_err set
    add(1,32'h40000004,0,0,0,0, 0,32'h30000003,0,1, 1,1,0,0);
    add(0,0,0,0,0,0,            1,32'h40000004,0,0, 0,1,1,0);
    // head-only then head again inside the packet
    add(1,32'h50000001,1,0,0,0, 0,32'h40000004,0,0, 1,1,1,0);
    add(1,32'h50000002,1,1,0,0, 1,32'h50000001,1,0, 1,1,1,0);
    add(0,0,0,0,0,0,            1,32'h50000002,1,1, 0,1,1,0);

    drive(0,0,0,0,0,0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      vidx = i;
      drive(vq[i].nw, vq[i].d, vq[i].h, vq[i].t, vq[i].dpf, vq[i].dfu);
      #1 chk("pre_full", 32'(pre_full), 32'(vq[i].pf));
      @(posedge clk); #1;
      chk_post(vq[i].onew, vq[i].od, vq[i].oh, vq[i].ot, vq[i].cnt, vq[i].ovf, vq[i].ferr);
    end

    // reset mid-packet: queued flits discarded, sticky flags cleared
    vidx = 1000;
    drive(1,32'h60000001,1,0,1,0);
    @(posedge clk); #1;
    chk("count_before_reset", 32'(count), 32'd1);
    drive(0,0,0,0,0,0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_post(0, 32'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      vidx = 1001 + i;
      @(posedge clk); #1;
      chk_post(0, 32'h0, 0, 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
